spy_event_reader: RTL

//  Downstream readout stage of the spy buffer. Runs only while the spy buffer is frozen.

---
 rtl/spy_reader_pkg.sv | 22 ++
 rtl/spy_event_reader_if.sv | 17 +
 rtl/spy_reader_skid.sv | 78 +++++++
 rtl/spy_event_reader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spy_reader_pkg.sv
// Shared definitions for the spy buffer event reader.
//   - FSM state encoding (legacy-compatible localparam constants)
//   - HEADER_CODE tag carried in the optional header word
//   - sentinel bit index helper for event-list entries
package spy_reader_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_WALK   = 3'd1;
    localparam state_t ST_LEN    = 3'd2;
    localparam state_t ST_STREAM = 3'd3;
    localparam state_t ST_DONE   = 3'd4;

    localparam logic [7:0] HEADER_CODE = 8'hE5;

    // Event-list entries are {sentinel, address}; the sentinel sits just above the address.
    function automatic int sentinel_bit(input int memwidth);
        return memwidth;
    endfunction

endpackage

// File: rtl/spy_event_reader_if.sv
// Output stream bundle of the spy event reader.
//   out_data  : stream word (W bits)
//   out_valid : word present
//   out_ready : sink accepts word
//   out_last  : final word of the transfer
// master = reader side, slave = sink side.
interface spy_event_reader_if #(
    parameter int W = 65
);
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/spy_reader_skid.sv
// Two-entry valid/ready skid buffer for spy stream words.
// Ports:
//   clock, reset     : clock, synchronous active-high reset
//   flush            : drop all held words
//   push, push_data  : write one word (caller guarantees room via almost_full)
//   out_ready        : sink ready
//   out_data/valid   : head word
//   almost_full      : occupancy after this cycle will be 2; a read issued now
//                      would have nowhere to land next cycle
module spy_reader_skid
    import spy_reader_pkg::*;
#(
    parameter int WIDTH = 65
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             almost_full
);

    logic [WIDTH-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
    logic [1:0]       count_q, count_d, count_nxt;
    logic             pop;

    assign out_valid   = (count_q != 2'd0);
    assign out_data    = ent0_q;
    assign pop         = out_valid && out_ready;
    assign almost_full = count_nxt[1];

    always_comb begin
        ent0_d    = ent0_q;
        ent1_d    = ent1_q;
        count_nxt = count_q;
        unique case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    ent0_d    = push_data;
                    count_nxt = 2'd1;
                end else if (count_q == 2'd1) begin
                    ent1_d    = push_data;
                    count_nxt = 2'd2;
                end
            end
            2'b01: begin
                ent0_d    = ent1_q;
                count_nxt = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    ent0_d = push_data;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = push_data;
                end
            end
            default: ;
        endcase
        count_d = flush ? 2'd0 : count_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/spy_event_reader.sv
// Spy buffer event reader: while the spy buffer is frozen, walks the event list
// backwards (skipping wrap sentinels), locates event ev_index, and streams its
// words from spy memory over valid/ready.
// Ports:
//   clock, reset              : clock, synchronous active-high reset
//   frozen, start, ev_index   : request control
//   mem_wptr, meta_write_addr : spy memory / event list write pointers
//   meta_read_*               : event-list read port (data 1 cycle after strobe)
//   read_addr/enable, data_in : spy memory read port (data 1 cycle after strobe)
//   out_if (master)           : output stream
//   busy, done, error         : status (done/error are 1-cycle pulses)
// Build option: define SPY_READER_HEADER_EN to prefix each transfer with a header word
//   {1'b1, HEADER_CODE, zero pad, ev_index, start_addr, len}.
//
// State     | Meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for start (rejects start when not frozen)
// ST_WALK   | scanning event list backwards, 2 cycles per entry
// ST_LEN    | computing length, pushing header when enabled
// ST_STREAM | issuing spy memory reads and draining the skid buffer
// ST_DONE   | one-cycle done pulse
module spy_event_reader
    import spy_reader_pkg::*;
#(
    parameter int DATAWIDTH = 64,
    parameter int MEMWIDTH  = 6,
    parameter int METAWIDTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 frozen,
    input  logic                 start,
    input  logic [METAWIDTH-1:0] ev_index,
    input  logic [MEMWIDTH-1:0]  mem_wptr,
    input  logic [METAWIDTH-1:0] meta_write_addr,
    output logic [METAWIDTH-1:0] meta_read_addr,
    output logic                 meta_read_enable,
    input  logic [MEMWIDTH:0]    meta_read_data,
    output logic [MEMWIDTH-1:0]  read_addr,
    output logic                 read_enable,
    input  logic [DATAWIDTH:0]   data_in,
    spy_event_reader_if.master   out_if,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam int SNT = sentinel_bit(MEMWIDTH);
`ifdef SPY_READER_HEADER_EN
    localparam logic [MEMWIDTH:0] HDR_WORDS = 1;
    localparam int PAD = DATAWIDTH - 8 - METAWIDTH - 2 * MEMWIDTH;
`else
    localparam logic [MEMWIDTH:0] HDR_WORDS = 0;
`endif

    state_t                state_q, state_d;
    logic [METAWIDTH-1:0]  ev_idx_q, ev_idx_d;
    logic [METAWIDTH-1:0]  ptr_q, ptr_d;
    logic                  phase_q, phase_d;
    logic [METAWIDTH-1:0]  visited_q, visited_d;
    logic [METAWIDTH-1:0]  match_q, match_d;
    logic [MEMWIDTH-1:0]   prev_q, prev_d;
    logic [MEMWIDTH-1:0]   start_q, start_d;
    logic [MEMWIDTH-1:0]   end_q, end_d;
    logic [MEMWIDTH-1:0]   len_q, len_d;
    logic [MEMWIDTH:0]     total_q, total_d;
    logic [MEMWIDTH-1:0]   rd_cnt_q, rd_cnt_d;
    logic [MEMWIDTH:0]     sent_q, sent_d;
    logic                  inflight_q, inflight_d;
    logic                  err_q, err_d;

    logic                  issue, hdr_push, flush, pop, hit;
    logic [MEMWIDTH-1:0]   len_calc;
    logic                  skid_push, skid_valid, skid_afull;
    logic [DATAWIDTH:0]    skid_din, skid_dout;

    assign len_calc = end_q - start_q;
    assign pop      = skid_valid && out_if.out_ready;

`ifdef SPY_READER_HEADER_EN
    logic [DATAWIDTH:0] hdr_word;
    assign hdr_word = {1'b1, HEADER_CODE, {PAD{1'b0}}, ev_idx_q, start_q, len_calc};
    assign skid_din = hdr_push ? hdr_word : data_in;
`else
    assign skid_din = data_in;
`endif
    assign skid_push = hdr_push | inflight_q;

    always_comb begin
        state_d   = state_q;
        ev_idx_d  = ev_idx_q;
        ptr_d     = ptr_q;
        phase_d   = phase_q;
        visited_d = visited_q;
        match_d   = match_q;
        prev_d    = prev_q;
        start_d   = start_q;
        end_d     = end_q;
        len_d     = len_q;
        total_d   = total_q;
        rd_cnt_d  = rd_cnt_q;
        sent_d    = sent_q;
        err_d     = 1'b0;
        issue     = 1'b0;
        hdr_push  = 1'b0;
        flush     = 1'b0;
        hit       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (frozen) begin
                        state_d   = ST_WALK;
                        ev_idx_d  = ev_index;
                        ptr_d     = meta_write_addr - 1'b1;
                        phase_d   = 1'b0;
                        visited_d = '0;
                        match_d   = '0;
                        prev_d    = mem_wptr;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_WALK: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d   = 1'b0;
                    ptr_d     = ptr_q - 1'b1;
                    visited_d = visited_q + 1'b1;
                    if (!meta_read_data[SNT]) begin
                        if (match_q == ev_idx_q) begin
                            hit     = 1'b1;
                            start_d = meta_read_data[MEMWIDTH-1:0];
                            end_d   = prev_q;
                            state_d = ST_LEN;
                        end else begin
                            match_d = match_q + 1'b1;
                            prev_d  = meta_read_data[MEMWIDTH-1:0];
                        end
                    end
                    if (!hit && visited_q == '1) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_LEN: begin
                len_d    = len_calc;
                total_d  = {1'b0, len_calc} + HDR_WORDS;
                rd_cnt_d = '0;
                sent_d   = '0;
                hdr_push = (HDR_WORDS != '0);
                state_d  = (total_d == '0) ? ST_DONE : ST_STREAM;
            end
            ST_STREAM: begin
                // Reads are gated on room for the word that lands next cycle.
                issue = frozen && (rd_cnt_q != len_q) && !skid_afull;
                if (issue) rd_cnt_d = rd_cnt_q + 1'b1;
                if (pop) begin
                    sent_d = sent_q + 1'b1;
                    if (out_if.out_last) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (state_q != ST_IDLE && !frozen) begin
            state_d  = ST_IDLE;
            flush    = 1'b1;
            err_d    = 1'b1;
            issue    = 1'b0;
            hdr_push = 1'b0;
        end
        inflight_d = issue;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ev_idx_q   <= '0;
            ptr_q      <= '0;
            phase_q    <= 1'b0;
            visited_q  <= '0;
            match_q    <= '0;
            prev_q     <= '0;
            start_q    <= '0;
            end_q      <= '0;
            len_q      <= '0;
            total_q    <= '0;
            rd_cnt_q   <= '0;
            sent_q     <= '0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ev_idx_q   <= ev_idx_d;
            ptr_q      <= ptr_d;
            phase_q    <= phase_d;
            visited_q  <= visited_d;
            match_q    <= match_d;
            prev_q     <= prev_d;
            start_q    <= start_d;
            end_q      <= end_d;
            len_q      <= len_d;
            total_q    <= total_d;
            rd_cnt_q   <= rd_cnt_d;
            sent_q     <= sent_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    spy_reader_skid #(.WIDTH(DATAWIDTH + 1)) u_skid (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .push        (skid_push),
        .push_data   (skid_din),
        .out_ready   (out_if.out_ready),
        .out_data    (skid_dout),
        .out_valid   (skid_valid),
        .almost_full (skid_afull)
    );

    assign out_if.out_data   = skid_dout;
    assign out_if.out_valid  = skid_valid;
    assign out_if.out_last   = skid_valid && (sent_q == total_q - 1'b1);

    assign meta_read_addr   = ptr_q;
    assign meta_read_enable = (state_q == ST_WALK) && !phase_q;
    assign read_addr        = start_q + rd_cnt_q;
    assign read_enable      = issue;
    assign busy             = (state_q != ST_IDLE);
    assign done             = (state_q == ST_DONE);
    assign error            = err_q;

endmodule
